// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state encoding, character width and default bit timing.
package uart_pkg;

    localparam int UART_DATA_W               = 7;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/odd_parity_gen.sv
// Combinational odd-parity generator: the output makes data plus parity carry an odd number of ones.
module odd_parity_gen
    import uart_pkg::*;
(
    input  logic [UART_DATA_W-1:0] data_i,
    output logic                   parity_o
);

    assign parity_o = ~(^data_i);

endmodule

// File: rtl/tx_frame_serializer.sv
// UART transmit framer/serializer: start, 7 data bits LSB first, odd parity, stop bit(s).
// Define TX_TWO_STOP_EN to send two stop bits instead of one.
module tx_frame_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [UART_DATA_W-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   tx_serial,
    output logic                   tx_busy,
    output logic                   tx_done
);

    localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BAUD_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]       DATA_LAST = 3'(UART_DATA_W - 1);
`ifdef TX_TWO_STOP_EN
    localparam logic [2:0]       STOP_LAST = 3'd1;
`else
    localparam logic [2:0]       STOP_LAST = 3'd0;
`endif

    tx_state_t              state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [2:0]             idx_q;
    logic [UART_DATA_W-1:0] shift_q;
    logic                   parity_q;
    logic                   serial_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   par_bit;
    logic                   baud_end;
    logic                   last_stop;

    // Shift register is untouched during START, so it still holds the accepted character.
    odd_parity_gen u_parity (
        .data_i   (shift_q),
        .parity_o (par_bit)
    );

    assign baud_end  = (cnt_q == BAUD_LAST);
    assign last_stop = (state_q == STOP) && (idx_q == STOP_LAST);

    assign tx_ready  = (state_q == IDLE);
    assign tx_serial = serial_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // The line follows the state one cycle later; busy and done track the state itself.
            case (state_q)
                START:   serial_q <= 1'b0;
                DATA:    serial_q <= shift_q[0];
                PARITY:  serial_q <= parity_q;
                default: serial_q <= 1'b1;
            endcase

            done_q <= last_stop && (cnt_q == BAUD_PRE);

            if (state_q == START) begin
                parity_q <= par_bit;
            end

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    if (tx_valid) begin
                        shift_q <= tx_data;
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (baud_end) begin
                        cnt_q   <= '0;
                        state_q <= DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        cnt_q   <= '0;
                        shift_q <= shift_q >> 1;
                        if (idx_q == DATA_LAST) begin
                            idx_q   <= '0;
                            state_q <= PARITY;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                PARITY: begin
                    if (baud_end) begin
                        cnt_q   <= '0;
                        state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        cnt_q <= '0;
                        if (last_stop) begin
                            idx_q   <= '0;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/tx_frame_serializer.md
# tx_frame_serializer

- UART transmit framer and serializer: accepts one 7-bit character per valid/ready handshake and shifts it onto the serial line.
- Frame order: start bit, 7 data bits LSB first, odd parity bit, stop bit(s).
- Sits between the host-side transmit source and the TX pin. The parity bit comes from an odd-parity generator instance on the latched character.
- Bit timing comes from an internal clock-divider counter; no external baud tick.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit (50 MHz / 115200). Legal range ≥ 2.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `tx_data` input 7: character to send. Sampled only on the accept cycle.
- `tx_valid` input 1: source has a character.
- `tx_ready` output 1: block can accept a character. High only in IDLE.
- `tx_serial` output 1: serial line, idle high.
- `tx_busy` output 1: a frame is in progress (any state other than IDLE).
- `tx_done` output 1: single-cycle pulse on the last cycle of the final stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Accept: `tx_valid && tx_ready` on a rising edge.
  - Latch `tx_data` into the shift register.
  - Latch the parity bit = NOT(XOR of the 7 data bits), i.e. odd parity over data+parity.
  - Clear the baud counter and bit index; go to START.
- START: drive `tx_serial`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA: drive shift register bit 0. Every `CLKS_PER_BIT` cycles, shift right and increment the 3-bit index. After index 6 completes, go to PARITY.
- PARITY: drive the latched parity bit for one bit period, then go to STOP.
- STOP: drive 1 for one bit period (two with the macro), then go to IDLE. `tx_done` pulses on the last cycle.
- Baud counter:
  - Width `$clog2(CLKS_PER_BIT)`.
  - Counts 0..`CLKS_PER_BIT`-1; a bit ends when the count equals `CLKS_PER_BIT`-1.
  - Wraps to 0 on every bit boundary. Never free-runs in IDLE; held at 0 there.
- `tx_data` changes after acceptance are ignored until the next accept.
- `tx_valid` deasserted mid-frame has no effect. There is no abort.
- Reset, including mid-frame: state=IDLE, `tx_serial`=1, `tx_busy`=0, `tx_done`=0, `tx_ready`=1, counters=0, shift/parity registers=0. Reset takes effect immediately (async), truncating any frame with the line high.

## Timing
- `tx_serial`, `tx_busy` and `tx_done` are registered outputs. `tx_ready` is decoded from the state register.
- Accept at edge N → `tx_serial` falls at edge N+1 (one-cycle latency).
- Frame length on the line: 10×`CLKS_PER_BIT` cycles (11× with two stop bits).
- `tx_done` is high for exactly the one cycle before the state returns to IDLE.
- `tx_ready` rises in the cycle after `tx_done`.
- Back-to-back sends with `tx_valid` held high: the next accept happens on the first IDLE edge. The line therefore stays high one extra cycle between frames, giving a frame period of 10×`CLKS_PER_BIT`+1.
- `tx_valid` while busy is not accepted and not lost-by-design; the source holds it until `tx_ready`.

## Configuration
- `TX_TWO_STOP_EN` defined: STOP lasts 2 bit periods, the frame is 11 bit periods, and `tx_done` pulses on the last cycle of the second stop bit.
- Undefined: one stop bit, 10-bit frame.
- No other behaviour changes.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - `UART_DATA_W`=7;
  - `UART_DEFAULT_CLKS_PER_BIT`=434.
- One sub-module, `odd_parity_gen`: combinational, 7-bit input, 1-bit output NOT(^data). Instanced on the latched shift-register contents at accept time, before any shifting.

## Test plan
Run with `CLKS_PER_BIT`=4 unless stated.
- Reset then idle: `rst_n` low then high, no `tx_valid` → `tx_serial`=1, `tx_ready`=1, `tx_busy`=0, `tx_done` never asserts for 100 cycles.
- Single frame: `tx_data`=7'h41, pulse `tx_valid` → line bits 0,1,0,0,0,0,0,1,1(parity),1, each exactly 4 cycles. Start bit begins 1 cycle after accept. `tx_done` is one pulse at cycle 40 of the frame.
- Parity odd case: `tx_data`=7'h07 → parity bit 0. `tx_data`=7'h00 → parity bit 1. `tx_data`=7'h7F → parity bit 0.
- Back-to-back: `tx_valid` held high with 7'h55 then 7'h2A → two correct frames, exactly 1 idle-high cycle between them. Changing `tx_data` mid-frame does not alter the first frame.
- Reset mid-frame: assert `rst_n` low during DATA bit 3 → `tx_serial`=1 and `tx_ready`=1 asynchronously. A new accept after release sends a complete clean frame.
- `TX_TWO_STOP_EN` build: 7'h41 → 11-bit-period frame, stop high for 8 cycles, `tx_done` at cycle 44.
